uart_receiver: RTL and testbench

UART_RECEIVER -- requirements
Module: uart_receiver

---
 rtl/uart_pkg.sv | 15 +
 rtl/uart_baud_counter.sv | 36 +++
 rtl/uart_receiver.sv | 133 +++++++++++++
 tb/tb_uart_receiver.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding, default bit timing and
// data width. The transmitter uses this package as well.
package uart_pkg;

    localparam int CLKS_PER_BIT_DEFAULT = 868;  // 100 MHz / 115200 baud
    localparam int UART_DATA_BITS       = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } rx_state_t;

endpackage

// File: rtl/uart_baud_counter.sv
// Bit-period counter. Counts up from 0 while enabled and wraps after the last
// cycle of a bit. Flags the last cycle of a half bit and of a full bit.
module uart_baud_counter
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT
) (
    input  logic CLK,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic half_tc,
    output logic full_tc
);
    localparam int            CW        = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] FULL_LAST = CW'(CLKS_PER_BIT - 1);

    logic [CW-1:0] cnt;

    assign half_tc = (cnt == HALF_LAST);
    assign full_tc = (cnt == FULL_LAST);

    // Counter register: clear has priority, wrap keeps cnt <= CLKS_PER_BIT-1.
    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            cnt <= '0;
        end else if (clear) begin
            cnt <= '0;
        end else if (enable) begin
            if (full_tc) cnt <= '0;
            else         cnt <= cnt + CW'(1);
        end
    end

endmodule

// File: rtl/uart_receiver.sv
// 8N1 UART receiver with a one-entry output holding register.
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | line idle, waiting for rx_s low
// START | timing to mid start bit; high there means glitch, back to IDLE
// DATA  | sampling 8 data bits at mid-bit, LSB first
// STOP  | sampling stop bit: high delivers byte, low flags frame_err
module uart_receiver
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT
) (
    input  logic       CLK,
    input  logic       reset,
    input  logic       rx,
    input  logic       rx_ack,
    output logic [7:0] rx_byte,
    output logic       rx_valid,
    output logic       busy_rx,
    output logic       frame_err,
    output logic       overrun
);
    rx_state_t                 state, next_state;
    logic [1:0]                sync;
    logic                      rx_s;
    logic                      cnt_clear, cnt_en, half_tc, full_tc;
    logic [2:0]                bit_cnt;
    logic [UART_DATA_BITS-1:0] shift;
    logic                      clr_bits, sample_bit, stop_ok, stop_bad;

    uart_baud_counter #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_baud (
        .CLK     (CLK),
        .reset   (reset),
        .clear   (cnt_clear),
        .enable  (cnt_en),
        .half_tc (half_tc),
        .full_tc (full_tc)
    );

    // Two-flop synchronizer; resets to the idle-high line level.
    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) sync <= 2'b11;
        else        sync <= {sync[0], rx};
    end

    assign rx_s    = sync[1];
    assign busy_rx = (state != IDLE);

    // State register.
    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= next_state;
    end

    // Next-state and per-cycle control decode.
    always_comb begin
        next_state = state;
        cnt_clear  = 1'b0;
        cnt_en     = 1'b0;
        clr_bits   = 1'b0;
        sample_bit = 1'b0;
        stop_ok    = 1'b0;
        stop_bad   = 1'b0;
        case (state)
            IDLE: begin
                cnt_clear = 1'b1;
                if (!rx_s) next_state = START;
            end
            START: begin
                cnt_en = 1'b1;
                if (half_tc) begin
                    cnt_clear = 1'b1;
                    if (!rx_s) begin
                        next_state = DATA;
                        clr_bits   = 1'b1;
                    end else begin
                        next_state = IDLE;
                    end
                end
            end
            DATA: begin
                cnt_en = 1'b1;
                if (full_tc) begin
                    sample_bit = 1'b1;
                    if (bit_cnt == 3'd7) next_state = STOP;
                end
            end
            STOP: begin
                cnt_en = 1'b1;
                if (full_tc) begin
                    next_state = IDLE;
                    if (rx_s) stop_ok  = 1'b1;
                    else      stop_bad = 1'b1;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    // Data shift register and bit counter.
    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            bit_cnt <= 3'd0;
            shift   <= '0;
        end else if (clr_bits) begin
            bit_cnt <= 3'd0;
        end else if (sample_bit) begin
            shift   <= {rx_s, shift[UART_DATA_BITS-1:1]};
            bit_cnt <= bit_cnt + 3'd1;
        end
    end

    // Output holding register; a same-cycle ack frees the slot, so no overrun.
    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            rx_byte   <= 8'h00;
            rx_valid  <= 1'b0;
            frame_err <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            frame_err <= stop_bad;
            if (stop_ok) begin
                rx_byte  <= shift;
                rx_valid <= 1'b1;
                if (rx_valid && !rx_ack) overrun <= 1'b1;
            end else if (rx_ack) begin
                rx_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_uart_receiver.sv
// Directed bench for uart_receiver at 16 clocks per bit.
module tb_uart_receiver;
    localparam int CPB = 16;
    localparam int FRAME_CYC = 10 * CPB;
    // Stop-bit sampling edge, counted from the first frame cycle: 2 sync
    // flops, 1 IDLE edge, half bit, 8 data bits, 1 stop bit.
    localparam int ACK_ITER = 2 + 1 + CPB / 2 + 9 * CPB - 1;

    logic       CLK = 1'b0;
    logic       reset, rx, rx_ack;
    logic [7:0] rx_byte;
    logic       rx_valid, busy_rx, frame_err, overrun;

    int checks = 0;
    int errors = 0;
    int ferr_cnt = 0;
    int f0;

    typedef struct {
        logic       rst_before;
        logic [7:0] data;
        logic       stop;
        logic       ack_end;
        logic       ack_after;
        logic [7:0] exp_byte;
        logic       exp_valid;
        int         exp_ferr;
        logic       exp_ovr;
        logic       exp_valid_after;
    } vec_t;

    vec_t vecs [6];

    always #5 CLK = ~CLK;

    uart_receiver #(.CLKS_PER_BIT(CPB)) dut (
        .CLK       (CLK),
        .reset     (reset),
        .rx        (rx),
        .rx_ack    (rx_ack),
        .rx_byte   (rx_byte),
        .rx_valid  (rx_valid),
        .busy_rx   (busy_rx),
        .frame_err (frame_err),
        .overrun   (overrun)
    );

    // Count cycles with frame_err high.
    always @(negedge CLK) if (frame_err === 1'b1) ferr_cnt <= ferr_cnt + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual %0h required %0h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge CLK);
            #1;
        end
    endtask

    // Drive ncyc cycles of an 8N1 frame; optional ack on the stop-sample edge.
    task automatic send_frame(input logic [7:0] d, input logic stop, input logic ack_end,
                              input int ncyc);
        int   idx;
        logic b;
        for (int c = 0; c < ncyc; c++) begin
            idx = c / CPB;
            if (idx == 0)      b = 1'b0;
            else if (idx <= 8) b = d[idx-1];
            else               b = stop;
            rx     = b;
            rx_ack = ack_end && (c == ACK_ITER);
            tick(1);
        end
        rx     = 1'b1;
        rx_ack = 1'b0;
    endtask

    initial begin
        vecs[0] = '{1'b0, 8'h3C, 1'b0, 1'b0, 1'b1, 8'h00, 1'b0, 1, 1'b0, 1'b0};
        vecs[1] = '{1'b0, 8'hA5, 1'b1, 1'b0, 1'b1, 8'hA5, 1'b1, 0, 1'b0, 1'b0};
        vecs[2] = '{1'b0, 8'h11, 1'b1, 1'b0, 1'b0, 8'h11, 1'b1, 0, 1'b0, 1'b1};
        vecs[3] = '{1'b0, 8'h22, 1'b1, 1'b0, 1'b1, 8'h22, 1'b1, 0, 1'b1, 1'b0};
        vecs[4] = '{1'b1, 8'h55, 1'b1, 1'b0, 1'b0, 8'h55, 1'b1, 0, 1'b0, 1'b1};
        vecs[5] = '{1'b0, 8'h66, 1'b1, 1'b1, 1'b1, 8'h66, 1'b1, 0, 1'b0, 1'b0};

        reset  = 1'b0;
        rx     = 1'b1;
        rx_ack = 1'b0;
        tick(2);
        @(negedge CLK);
        check("rst_byte", rx_byte, 8'h00);
        check("rst_valid", rx_valid, 1'b0);
        check("rst_ferr", frame_err, 1'b0);
        check("rst_ovr", overrun, 1'b0);
        check("rst_busy", busy_rx, 1'b0);
        @(posedge CLK);
        #1 reset = 1'b1;
        tick(5);

        // Four-cycle low glitch: START entered, then abandoned at mid start bit.
        f0 = ferr_cnt;
        rx = 1'b0;
        tick(4);
        rx = 1'b1;
        tick(2);
        @(negedge CLK);
        check("glitch_busy_hi", busy_rx, 1'b1);
        tick(5);
        @(negedge CLK);
        check("glitch_busy_lo", busy_rx, 1'b0);
        check("glitch_valid", rx_valid, 1'b0);
        check("glitch_byte", rx_byte, 8'h00);
        check("glitch_ferr", ferr_cnt - f0, 0);
        tick(10);

        for (int i = 0; i < 6; i++) begin
            if (vecs[i].rst_before) begin
                reset = 1'b0;
                tick(2);
                reset = 1'b1;
                tick(2);
            end
            f0 = ferr_cnt;
            send_frame(vecs[i].data, vecs[i].stop, vecs[i].ack_end, FRAME_CYC);
            tick(20);
            @(negedge CLK);
            check($sformatf("v%0d_byte", i), rx_byte, vecs[i].exp_byte);
            check($sformatf("v%0d_valid", i), rx_valid, vecs[i].exp_valid);
            check($sformatf("v%0d_ferr", i), ferr_cnt - f0, vecs[i].exp_ferr);
            check($sformatf("v%0d_ovr", i), overrun, vecs[i].exp_ovr);
            if (vecs[i].ack_after) begin
                @(posedge CLK);
                #1 rx_ack = 1'b1;
                tick(1);
                rx_ack = 1'b0;
                @(negedge CLK);
                check($sformatf("v%0d_valid_ack", i), rx_valid, vecs[i].exp_valid_after);
                check($sformatf("v%0d_ovr_ack", i), overrun, vecs[i].exp_ovr);
            end
            tick(5);
        end

        // Reset during data bit 4 of 8'hFF, then a clean 8'h0F.
        f0 = ferr_cnt;
        send_frame(8'hFF, 1'b1, 1'b0, 5 * CPB + 8);
        @(negedge CLK);
        check("abort_busy_pre", busy_rx, 1'b1);
        reset = 1'b0;
        @(negedge CLK);
        check("abort_byte", rx_byte, 8'h00);
        check("abort_valid", rx_valid, 1'b0);
        check("abort_ferr", frame_err, 1'b0);
        check("abort_ovr", overrun, 1'b0);
        check("abort_busy", busy_rx, 1'b0);
        tick(2);
        reset = 1'b1;
        tick(40);
        @(negedge CLK);
        check("post_abort_valid", rx_valid, 1'b0);
        check("post_abort_busy", busy_rx, 1'b0);
        check("post_abort_ferr", ferr_cnt - f0, 0);
        tick(1);
        send_frame(8'h0F, 1'b1, 1'b0, FRAME_CYC);
        tick(20);
        @(negedge CLK);
        check("final_byte", rx_byte, 8'h0F);
        check("final_valid", rx_valid, 1'b1);
        check("final_ferr", ferr_cnt - f0, 0);
        check("final_ovr", overrun, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
